// File: rtl/tile_wr_sequencer_pkg.sv
// ============================================================================
// tile_wr_sequencer_pkg : shared sizes and FSM encodings for tile write-back
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package tile_wr_sequencer_pkg;
   localparam int         c_width_height = 16;
   localparam int         c_addr_w       = 8;
   localparam logic [1:0] c_st_idle      = 2'd0;
   localparam logic [1:0] c_st_run       = 2'd1;
   localparam logic [1:0] c_st_done      = 2'd2;
endpackage

`default_nettype wire

// File: rtl/wr_skew_stage.sv
// ============================================================================
// wr_skew_stage : one bank's {en, addr} register in the diagonal write wave
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module wr_skew_stage #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_clear,
   input  logic              i_en,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              o_en,
   output logic [ADDR_W-1:0] o_addr
);
   logic              r_en;
   logic [ADDR_W-1:0] r_addr;

   // Clear only kills the enable; a held address is don't-care while en=0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_en   <= 1'b0;
         r_addr <= '0;
      end else begin
         r_en   <= i_en & ~i_clear;
         r_addr <= i_addr;
      end
   end

   assign o_en   = r_en;
   assign o_addr = r_addr;
endmodule

`default_nettype wire

// File: rtl/tile_wr_sequencer.sv
// ============================================================================
// tile_wr_sequencer : generates the skewed per-bank write wave for one tile
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tile_wr_sequencer
   import tile_wr_sequencer_pkg::*;
#(
   parameter int WIDTH_HEIGHT = c_width_height,
   parameter int ADDR_W       = c_addr_w
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           start,
   input  logic [ADDR_W-1:0]              base_addr,
   input  logic [ADDR_W-1:0]              num_rows,
   input  logic                           abort,
   output logic                           busy,
   output logic                           done,
   output logic [WIDTH_HEIGHT-1:0]        wr_en,
   output logic [ADDR_W*WIDTH_HEIGHT-1:0] wr_addr
);
   localparam int c_cnt_w = ADDR_W + $clog2(WIDTH_HEIGHT) + 1;

   logic [1:0]         r_state;
   logic [c_cnt_w-1:0] r_cnt;
   logic [ADDR_W-1:0]  r_base;
   logic [ADDR_W-1:0]  r_rows;
   logic               r_busy;
   logic               r_done;

   logic               w_abort;
   logic               w_accept;
   logic               w_last;
   logic [c_cnt_w-1:0] w_last_cnt;
   logic               w_head_en;
   logic [ADDR_W-1:0]  w_head_addr;
   logic               w_en   [WIDTH_HEIGHT];
   logic [ADDR_W-1:0]  w_addr [WIDTH_HEIGHT];

   assign w_abort     = abort && (r_state != c_st_idle);
   assign w_accept    = start && !abort && !r_busy && (r_state == c_st_idle);
   assign w_last_cnt  = c_cnt_w'(r_rows) + c_cnt_w'(WIDTH_HEIGHT - 1);
   assign w_last      = (r_rows == '0) || (r_cnt == w_last_cnt);
   assign w_head_en   = (r_state == c_st_run) && (r_cnt < c_cnt_w'(r_rows));
   assign w_head_addr = r_base + r_cnt[ADDR_W-1:0];

   // After an abort busy stays up one extra cycle, so the IDLE branch gates
   // start on r_busy as well as on the state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= c_st_idle;
         r_cnt   <= '0;
         r_base  <= '0;
         r_rows  <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else if (w_abort) begin
         r_state <= c_st_idle;
         r_cnt   <= '0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            c_st_idle: begin
               r_done <= 1'b0;
               if (w_accept) begin
                  r_state <= c_st_run;
                  r_cnt   <= '0;
                  r_base  <= base_addr;
                  r_rows  <= num_rows;
                  r_busy  <= 1'b1;
               end else begin
                  r_busy  <= 1'b0;
               end
            end
            c_st_run: begin
               if (w_last) begin
                  r_state <= c_st_done;
                  r_done  <= 1'b1;
               end else begin
                  r_cnt   <= r_cnt + c_cnt_w'(1);
               end
            end
            c_st_done: begin
               r_state <= c_st_idle;
               r_cnt   <= '0;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= c_st_idle;
               r_cnt   <= '0;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   generate
      for (genvar i = 0; i < WIDTH_HEIGHT; i++) begin : g_stage
         logic              w_d_en;
         logic [ADDR_W-1:0] w_d_addr;

         if (i == 0) begin : g_head
            assign w_d_en   = w_head_en;
            assign w_d_addr = w_head_addr;
         end else begin : g_tail
            assign w_d_en   = w_en[i-1];
            assign w_d_addr = w_addr[i-1];
         end

         wr_skew_stage #(.ADDR_W(ADDR_W)) u_stage (
            .clk     (clk),
            .reset   (reset),
            .i_clear (w_abort),
            .i_en    (w_d_en),
            .i_addr  (w_d_addr),
            .o_en    (w_en[i]),
            .o_addr  (w_addr[i])
         );

         assign wr_en[i]                    = w_en[i];
         assign wr_addr[ADDR_W*i +: ADDR_W] = w_addr[i];
      end
   endgenerate

   assign busy = r_busy;
   assign done = r_done;
endmodule

`default_nettype wire

// File: tb/tb_tile_wr_sequencer.sv
// ============================================================================
// tb_tile_wr_sequencer : directed stimulus with a queue-based output scoreboard
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_tile_wr_sequencer;
   localparam int WH = 4;
   localparam int AW = 8;

   logic          clk       = 1'b0;
   logic          reset     = 1'b1;
   logic          start     = 1'b0;
   logic          abort     = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [AW-1:0] num_rows  = '0;
   logic          busy;
   logic          done;
   logic [WH-1:0] wr_en;
   logic [AW*WH-1:0] wr_addr;

   tile_wr_sequencer #(.WIDTH_HEIGHT(WH), .ADDR_W(AW)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .base_addr (base_addr),
      .num_rows  (num_rows),
      .abort     (abort),
      .busy      (busy),
      .done      (done),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          cyc;
      logic [3:0]  en;
      logic [31:0] addr;
      logic        done;
   } ev_t;

   ev_t exp_q[$];
   int  checks   = 0;
   int  failures = 0;

   // Test 1 reference wave (base 0x10, N=3), entries for cycles 1..7.
   logic [3:0]  t1_en   [7] = '{4'b0001, 4'b0011, 4'b0111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
   logic [31:0] t1_addr [7] = '{32'h0000_0010, 32'h0000_1011, 32'h0010_1112, 32'h1011_1200,
                                32'h1112_0000, 32'h1200_0000, 32'h0000_0000};

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic push_ev(int c, logic [3:0] en, logic [31:0] addr, logic d);
      ev_t e;
      e.cyc = c; e.en = en; e.addr = addr; e.done = d;
      exp_q.push_back(e);
   endtask

   task automatic push_t1(int e0, int upto);
      for (int j = 0; j < upto; j++)
         push_ev(e0 + j + 1, t1_en[j], t1_addr[j], (j == 6));
   endtask

   // Bank i writes row r in cycle e0+1+i+r; done lands in cycle e0+N+WH (e0+1 for N=0).
   task automatic push_tile(int e0, logic [7:0] base, int n);
      logic [3:0]  en;
      logic [31:0] addr;
      for (int c = 1; c < n + WH; c++) begin
         en = '0; addr = '0;
         for (int i = 0; i < WH; i++) begin
            int r;
            r = c - 1 - i;
            if (r >= 0 && r < n) begin
               en[i] = 1'b1;
               addr[8*i +: 8] = base + 8'(r);
            end
         end
         if (en != '0) push_ev(e0 + c, en, addr, 1'b0);
      end
      push_ev((n == 0) ? e0 + 1 : e0 + n + WH, 4'b0000, 32'h0, 1'b1);
   endtask

   task automatic issue(logic [7:0] b, logic [7:0] n, output int e0);
      @(negedge clk);
      start = 1'b1; base_addr = b; num_rows = n;
      e0 = cyc + 1;
      @(negedge clk);
      start = 1'b0;
   endtask

   logic [31:0] mon_addr;
   ev_t         mon_e;
   always @(negedge clk) begin
      if (!reset && (wr_en != '0 || done)) begin
         mon_addr = '0;
         for (int i = 0; i < WH; i++)
            if (wr_en[i]) mon_addr[8*i +: 8] = wr_addr[8*i +: 8];
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output: cycle=%0d wr_en=%b addr=%h done=%b required=none",
                     cyc, wr_en, mon_addr, done);
         end else begin
            mon_e = exp_q.pop_front();
            check("ev_cycle", 64'(cyc), 64'(mon_e.cyc));
            check("ev_wr_en", 64'(wr_en), 64'(mon_e.en));
            check("ev_wr_addr", 64'(mon_addr), 64'(mon_e.addr));
            check("ev_done", 64'(done), 64'(mon_e.done));
         end
      end
   end

   int e0;
   initial begin
      repeat (2) @(negedge clk);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_wr_en", 64'(wr_en), 64'd0);
      check("rst_wr_addr", 64'(wr_addr), 64'd0);
      reset = 1'b0;

      // Basic tile
      issue(8'h10, 8'd3, e0);
      push_t1(e0, 7);
      check("t1_busy_c0", 64'(busy), 64'd1);
      repeat (7) @(negedge clk);
      check("t1_busy_done", 64'(busy), 64'd1);
      @(negedge clk);
      check("t1_busy_idle", 64'(busy), 64'd0);
      check("t1_drain", 64'(exp_q.size()), 64'd0);

      // Address wrap
      issue(8'hFE, 8'd4, e0);
      push_tile(e0, 8'hFE, 4);
      repeat (9) @(negedge clk);
      check("t2_busy_idle", 64'(busy), 64'd0);
      check("t2_drain", 64'(exp_q.size()), 64'd0);

      // Zero rows
      issue(8'h33, 8'd0, e0);
      push_tile(e0, 8'h33, 0);
      check("t3_busy_c0", 64'(busy), 64'd1);
      @(negedge clk);
      check("t3_busy_c1", 64'(busy), 64'd1);
      check("t3_wr_en_c1", 64'(wr_en), 64'd0);
      @(negedge clk);
      check("t3_busy_c2", 64'(busy), 64'd0);
      check("t3_drain", 64'(exp_q.size()), 64'd0);

      // Start held high across a tile: one tile per accept, next begins after busy falls
      @(negedge clk);
      start = 1'b1; base_addr = 8'h40; num_rows = 8'd2;
      e0 = cyc + 1;
      push_tile(e0, 8'h40, 2);
      repeat (8) @(negedge clk);
      check("t4_busy_gap", 64'(busy), 64'd0);
      @(negedge clk);
      check("t4_busy_second", 64'(busy), 64'd1);
      start = 1'b0;
      push_tile(e0 + 8, 8'h40, 2);
      repeat (7) @(negedge clk);
      check("t4_busy_idle", 64'(busy), 64'd0);
      repeat (3) @(negedge clk);
      check("t4_no_third", 64'(busy), 64'd0);
      check("t4_drain", 64'(exp_q.size()), 64'd0);

      // Abort in cycle 3
      issue(8'h10, 8'd3, e0);
      push_t1(e0, 3);
      repeat (3) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("t5_wr_en_c4", 64'(wr_en), 64'd0);
      check("t5_done_c4", 64'(done), 64'd0);
      @(negedge clk);
      check("t5_busy_c5", 64'(busy), 64'd0);
      repeat (6) @(negedge clk);
      check("t5_drain", 64'(exp_q.size()), 64'd0);

      // Abort wins over start in IDLE
      @(negedge clk);
      start = 1'b1; abort = 1'b1; base_addr = 8'h55; num_rows = 8'd1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      check("t5b_busy", 64'(busy), 64'd0);
      repeat (6) @(negedge clk);
      check("t5b_busy_later", 64'(busy), 64'd0);

      // Asynchronous reset mid-run, then a clean tile
      issue(8'h10, 8'd3, e0);
      push_t1(e0, 3);
      repeat (3) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("t6_rst_wr_en", 64'(wr_en), 64'd0);
      check("t6_rst_wr_addr", 64'(wr_addr), 64'd0);
      check("t6_rst_busy", 64'(busy), 64'd0);
      check("t6_rst_done", 64'(done), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      check("t6_drain_rst", 64'(exp_q.size()), 64'd0);
      issue(8'h10, 8'd3, e0);
      push_t1(e0, 7);
      repeat (8) @(negedge clk);
      check("t6_busy_idle", 64'(busy), 64'd0);
      check("t6_drain", 64'(exp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

`default_nettype wire
